// File: rtl/cva6_instr_sink.sv
// cva6_instr_sink: receiving end of the shim instruction interface.
// Buffers RV32I words in a small FIFO, decodes the head entry as load, store,
// ALU-immediate or illegal, and retires in order. Loads and stores park the
// FSM until their single-bit memory response arrives.
//
// Handshake: an instruction transfers on a rising edge where instr_valid_i
// and instr_ready_o are both high. instr_ready_o depends only on registered
// FIFO occupancy (never on instr_valid_i), and instr_i is ignored whenever
// no transfer occurs.
module cva6_instr_sink #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic             load_mem_resp_i,
  input  logic             store_mem_resp_i,
  output logic             load_req_o,
  output logic             store_req_o,
  output logic             retire_valid_o,
  output logic [1:0]       retire_kind_o,
  output logic [4:0]       retire_rd_o,
  output logic [11:0]      retire_imm_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             spurious_resp_o,
  output logic [1:0]       dbg_state_o
);

  localparam int unsigned       PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] KIND_LOAD  = 2'd0;
  localparam logic [1:0] KIND_STORE = 2'd1;
  localparam logic [1:0] KIND_ALU   = 2'd2;
  localparam logic [1:0] KIND_ILL   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WAIT_ST = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;

  // Head decode
  logic [31:0] head;
  logic [6:0]  head_opcode;
  logic [2:0]  head_funct3;
  logic [1:0]  dec_kind;
  logic [4:0]  dec_rd;
  logic [11:0] dec_imm;
  logic        unused_rs1;

  // Fields of the load/store waiting for its response
  logic [1:0]  lat_kind;
  logic [4:0]  lat_rd;
  logic [11:0] lat_imm;

  logic pop_direct;   // popped entry retires without a memory access
  logic resp_retire;  // outstanding load/store completes this cycle
  logic retire_now;
  logic spur_now;

  assign full          = (count == DEPTH_CNT);
  assign empty         = (count == '0);
  assign instr_ready_o = !full;
  assign push          = instr_valid_i && !full;
  assign pop           = (state_q == IDLE) && !empty;

  assign head        = mem[rd_ptr];
  assign head_opcode = head[6:0];
  assign head_funct3 = head[14:12];
  // rs1/rs2 are not needed by the sink; only rd and the immediate retire.
  assign unused_rs1  = ^head[19:15];

  // Classify the head instruction and extract rd/imm
  always_comb begin
    dec_kind = KIND_ILL;
    dec_rd   = 5'd0;
    dec_imm  = 12'd0;
    case (head_opcode)
      7'b0000011: begin
        if (head_funct3 == 3'd2) begin
          dec_kind = KIND_LOAD;
          dec_rd   = head[11:7];
          dec_imm  = head[31:20];
        end
      end
      7'b0100011: begin
        if (head_funct3 == 3'd2) begin
          dec_kind = KIND_STORE;
          dec_imm  = {head[31:25], head[11:7]};
        end
      end
      7'b0010011: begin
        dec_kind = KIND_ALU;
        dec_rd   = head[11:7];
        dec_imm  = head[31:20];
      end
      default: begin
        dec_kind = KIND_ILL;
      end
    endcase
  end

  assign pop_direct  = pop && ((dec_kind == KIND_ALU) || (dec_kind == KIND_ILL));
  assign resp_retire = ((state_q == WAIT_LD) && load_mem_resp_i) ||
                       ((state_q == WAIT_ST) && store_mem_resp_i);
  assign retire_now  = pop_direct || resp_retire;
  // A response in the pop cycle of a load/store sees IDLE and is spurious.
  assign spur_now    = (load_mem_resp_i  && (state_q != WAIT_LD)) ||
                       (store_mem_resp_i && (state_q != WAIT_ST));

  assign dbg_state_o = state_q;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: park on a load/store until its own response arrives
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop && (dec_kind == KIND_LOAD)) begin
          state_d = WAIT_LD;
        end else if (pop && (dec_kind == KIND_STORE)) begin
          state_d = WAIT_ST;
        end
      end
      WAIT_LD: begin
        if (load_mem_resp_i) begin
          state_d = IDLE;
        end
      end
      WAIT_ST: begin
        if (store_mem_resp_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO data array; contents need no reset since count gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= instr_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Hold the decoded load/store fields until its response retires it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_kind <= KIND_LOAD;
      lat_rd   <= 5'd0;
      lat_imm  <= 12'd0;
    end else if (pop && !pop_direct) begin
      lat_kind <= dec_kind;
      lat_rd   <= dec_rd;
      lat_imm  <= dec_imm;
    end
  end

  // Registered request/retire pulses, retire fields, counter and sticky flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_req_o      <= 1'b0;
      store_req_o     <= 1'b0;
      retire_valid_o  <= 1'b0;
      retire_kind_o   <= 2'd0;
      retire_rd_o     <= 5'd0;
      retire_imm_o    <= 12'd0;
      retire_cnt_o    <= '0;
      spurious_resp_o <= 1'b0;
    end else begin
      load_req_o     <= pop && (dec_kind == KIND_LOAD);
      store_req_o    <= pop && (dec_kind == KIND_STORE);
      retire_valid_o <= retire_now;
      if (pop_direct) begin
        retire_kind_o <= dec_kind;
        retire_rd_o   <= dec_rd;
        retire_imm_o  <= dec_imm;
      end else if (resp_retire) begin
        retire_kind_o <= lat_kind;
        retire_rd_o   <= lat_rd;
        retire_imm_o  <= lat_imm;
      end
      if (retire_now) begin
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
      if (spur_now) begin
        spurious_resp_o <= 1'b1;
      end
    end
  end

endmodule
